// File: rtl/shift_left_iter_pkg.sv
// Shared types and constants for the iterative left shifter/rotator.
package shl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_ROL = 1'b1;

endpackage

// File: rtl/shift_left_iter_if.sv
// Request/response handshake bundle for shift_left_iter.
// out_ovf exists only when SHL_OVF_FLAG_EN is defined.
interface shift_left_iter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_cnt;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef SHL_OVF_FLAG_EN
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_cnt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
`else
  modport master (
    output in_valid, in_data, in_cnt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/shift_left_iter_shift_left2.sv
// One datapath step: shift or rotate left by 1 or 2 bits.
// ShOut carries the bits leaving the MSB end (right-aligned when Two=0).
module shift_left2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] In,
  input  logic             Two,
  input  logic             Rot,
  output logic [WIDTH-1:0] Out,
  output logic [1:0]       ShOut
);

  always_comb begin
    Out   = '0;
    ShOut = '0;
    if (Two) begin
      ShOut = In[WIDTH-1:WIDTH-2];
      Out   = {In[WIDTH-3:0], (Rot ? In[WIDTH-1:WIDTH-2] : 2'b00)};
    end else begin
      ShOut = {1'b0, In[WIDTH-1]};
      Out   = {In[WIDTH-2:0], (Rot & In[WIDTH-1])};
    end
  end

endmodule

// File: rtl/shift_left_iter.sv
// Multi-cycle left shifter/rotator, up to 2 bits per cycle, valid/ready in and out.
// Define SHL_OVF_FLAG_EN to add the sticky logical-shift overflow flag (out_ovf).
module shift_left_iter
  import shl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_left_iter_if.slave    bus
);

  state_t           state;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] rem_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             op_reg;
  logic             two;

  assign two      = (rem_cnt >= CNT_W'(2));
  assign next_cnt = rem_cnt - (two ? CNT_W'(2) : CNT_W'(1));

`ifdef SHL_OVF_FLAG_EN
  logic [1:0] sh_out;
  logic       ovf_reg;
`else
  logic [1:0] sh_out_unused;
`endif

  shift_left2 #(.WIDTH(WIDTH)) u_shift (
    .In    (data_reg),
    .Two   (two),
    .Rot   (op_reg == OP_ROL),
    .Out   (shifted),
`ifdef SHL_OVF_FLAG_EN
    .ShOut (sh_out)
`else
    .ShOut (sh_out_unused)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_reg <= '0;
      rem_cnt  <= '0;
      op_reg   <= OP_SLL;
`ifdef SHL_OVF_FLAG_EN
      ovf_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_reg <= bus.in_data;
            rem_cnt  <= bus.in_cnt;
            op_reg   <= bus.in_op;
`ifdef SHL_OVF_FLAG_EN
            ovf_reg  <= 1'b0;
`endif
            state    <= (bus.in_cnt == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          data_reg <= shifted;
          rem_cnt  <= next_cnt;
`ifdef SHL_OVF_FLAG_EN
          // Only logical shifts lose bits; rotates recirculate them.
          ovf_reg  <= ovf_reg | ((op_reg == OP_SLL) & (|sh_out));
`endif
          if (next_cnt == '0) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = (state == DONE) ? data_reg : '0;
`ifdef SHL_OVF_FLAG_EN
  assign bus.out_ovf   = (state == DONE) & ovf_reg;
`endif

endmodule

// File: doc/shift_left_iter.md
Name: shift_left_iter

Overview:
- Multi-cycle left shifter/rotator: the left-direction counterpart of the design's right-shift stages.
- Accepts one operand, count and op through a valid/ready handshake and shifts by up to 2 bits per cycle.
- Presents the result through a valid/ready output handshake.
- Sits beside the ALU's combinational shifters; used where area matters more than single-cycle latency.

Parameters:
- WIDTH, 16, data width; must be a power of two.
- CNT_W, 4, count width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  WIDTH  operand.
- in_cnt  input  CNT_W  shift amount, 0..WIDTH-1.
- in_op  input  1  0 = shift left logical (zero fill), 1 = rotate left.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_ovf  output  1  present only with SHL_OVF_FLAG_EN.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async, rst_n=0): state IDLE; data_reg, rem_cnt, op_reg, ovf_reg all zero. Consequently in_ready=1, out_valid=0, out_data=0, out_ovf=0.
- IDLE: in_ready=1, out_valid=0.
  - Accept on an edge with in_valid=1: load data_reg=in_data, rem_cnt=in_cnt, op_reg=in_op, ovf_reg=0.
  - Next state is DONE if in_cnt==0, else BUSY.
- BUSY: in_ready=0, out_valid=0. Each edge:
  - Shift data_reg left by 2 if rem_cnt>=2, else by 1, and decrement rem_cnt by the same amount.
  - op_reg=0: vacated LSBs fill with 0.
  - op_reg=1: vacated LSBs take the bits shifted out of the MSB end, in order.
  - Next state is DONE when the post-update rem_cnt==0.
- Latency: out_valid rises on the ceil(in_cnt/2)-th edge after the accepting edge. in_cnt==0 means the accepting edge itself; in_cnt==15 means the 8th edge.
- DONE: out_valid=1, out_data=data_reg, in_ready=0.
  - Output is held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE. out_data returns to 0 in IDLE.
- Boundaries:
  - in_valid while not IDLE is ignored; no queueing.
  - Back-to-back operations: IDLE lasts at least one cycle between results.
  - rst_n asserted in any state aborts the in-flight operation immediately; nothing is emitted.
  - in_cnt cannot exceed WIDTH-1 by construction.
  - out_data always equals the full WIDTH-bit result; no truncation.

Optional Feature:
- Macro: SHL_OVF_FLAG_EN.
- Defined:
  - out_ovf port exists. It is 1 in DONE iff op_reg=0 and any 1 bit was shifted out of the MSB during the operation.
  - ovf_reg accumulates sticky across BUSY cycles and is cleared on accept and on reset.
  - out_ovf is 0 outside DONE and always 0 for rotate.
- Undefined: no out_ovf port and no ovf_reg; all other behaviour is identical.

Decomposition:
- Package shl_pkg holds:
  - State enum: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - Op constants: OP_SLL=1'b0, OP_ROL=1'b1.
- One combinational sub-module, shift_left2, instantiated once in the datapath:
  - Inputs: WIDTH-bit In, Two (0 = shift by 1, 1 = shift by 2), Rot.
  - Outputs: shifted Out, and ShOut (the 2-bit field shifted out, for ovf).
- FSM and registers live in shift_left_iter.

Test Plan:
1. Reset: drop rst_n mid-BUSY (op ROL 0x1234, cnt 9) -> same cycle in_ready=1, out_valid=0, out_data=0x0000; after release no result appears.
2. SLL 0x8001, cnt 1 -> out_valid on 1st edge after accept; out_data=0x0002; out_ovf=1 (if enabled).
3. ROL 0x8001, cnt 2 -> out_data=0x0006 on 1st edge.
4. ROL 0x1234, cnt 15 -> out_data=0x091A on 8th edge; out_ovf=0.
5. cnt 0, data 0xABCD, out_ready held 0 for 3 cycles -> out_data=0xABCD on the accepting edge, stable for 3 cycles, in_ready=0. A competing in_valid (0x1111) is ignored. IDLE follows the out_ready edge.
6. SLL 0xFFFF, cnt 15 -> 0x8000, ovf=1. Then SLL 0x0001, cnt 15 -> 0x8000, ovf=0. Confirm ovf is cleared between operations.
